fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter DEPTH, 2, fetch queue entries; legal values 2..8.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 StallD  input  1  decode cannot accept the head instruction this cycle.
REQ-006 PCSrcE  input  1  redirect request from execute (taken branch or jump).
REQ-007 PCTargetE  input  32  redirect target address.
REQ-008 ImemEn  output  1  instruction memory read strobe.
REQ-009 ImemAddr  output  32  instruction memory word address (byte address, bits [1:0] = 0).
REQ-010 ImemRdata  input  32  read data, valid exactly one cycle after the ImemEn cycle.
REQ-011 ValidD  output  1  head-of-queue instruction is valid.
REQ-012 InstrD  output  32  head instruction; bits [31:7] feed the decode immediate extender.
REQ-013 PCD  output  32  PC of head instruction.
REQ-014 PCPlus4D  output  32  PCD + 4, modulo 2^32.

Function
REQ-015 PCF register holds the next fetch address; ImemAddr = PCF when ImemEn = 1, else don't-care.
REQ-016 pop = ValidD && !StallD && !PCSrcE.
REQ-017 ImemEn = !PCSrcE && (count + inflight - pop < DEPTH); on issue, PCF <= PCF + 4 (wraps 32'hFFFF_FFFC -> 0).
REQ-018 inflight register is set on issue and cleared otherwise; it records the PC of the outstanding request.
REQ-019 When inflight = 1 and no redirect is active this cycle, {inflight PC, ImemRdata} is pushed into the queue at the clock edge.
REQ-020 ValidD = (count != 0); InstrD, PCD and PCPlus4D come from the head entry and are combinational from queue state only.
REQ-021 Latency: request in cycle N -> entry visible on ValidD in cycle N+2; steady state sustains one instruction per cycle with StallD = 0.
REQ-022 Simultaneous push and pop in one cycle: count unchanged, FIFO order preserved.
REQ-023 Overflow is impossible by construction (REQ-017); underflow is impossible because pop requires ValidD.
REQ-024 StallD = 1 holds the head entry and its outputs stable; fetching continues until the queue plus the in-flight slot is full, then ImemEn = 0.
REQ-025 PCSrcE = 1: at the edge, queue emptied (count <= 0), inflight cleared (a returning response is discarded), PCF <= {PCTargetE[31:2], 2'b00}; no issue and no pop in that cycle.
REQ-026 The cycle after a redirect, fetch issues from the target; its instruction appears on ValidD two cycles after that.
REQ-027 Back-to-back redirects: the last one wins; each one discards all prior state.
REQ-028 PCSrcE takes priority over StallD.

Reset
REQ-029 rst asserted: PCF = RESET_PC, count = 0, queue pointers = 0, inflight = 0, ValidD = 0, ImemEn = 0 immediately (asynchronous).
REQ-030 rst asserted mid-operation discards queued and in-flight instructions; the first issue occurs on the first rising edge after deassertion, from RESET_PC.
REQ-031 Queue data storage is not reset; only control state is reset.

Structure
REQ-032 A shared package holds the fetch_entry_t typedef {pc[31:0], instr[31:0]} and the NOP constant 32'h0000_0013.
REQ-033 One sub-module, fetch_fifo (parameterised DEPTH, push/pop/flush, count output), holds the queue; fetch_unit holds PCF, the issue logic and the inflight logic.
REQ-034 Outputs carry no X when ValidD = 1; InstrD = NOP when ValidD = 0.

Verification
REQ-035 Reset release, StallD = 0, memory returns addr-tagged data -> ImemAddr 0,4,8,... in consecutive cycles; ValidD rises 2 cycles after the first issue; PCD = 0,4,8,... each cycle.
REQ-036 StallD = 1 for 5 cycles with the head at PCD = 8 -> InstrD/PCD are held, ImemEn drops after the queue fills, no instruction is lost or duplicated after release.
REQ-037 PCSrcE = 1 with PCTargetE = 32'h0000_0100 while the queue is full -> next cycle ValidD = 0 and ImemAddr = 0x100; the next valid PCD = 0x100; the discarded response never appears.
REQ-038 PCTargetE = 32'h0000_0103 -> fetch from 0x100.
REQ-039 RESET_PC = 32'hFFFF_FFF8, free run -> PCD sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4D of FFFF_FFFC = 0.
REQ-040 rst asserted asynchronously mid-stream with 2 entries queued -> ValidD = 0 before the next edge; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  // One fetch-queue entry: the instruction together with the PC it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Presented on InstrD whenever no valid instruction is at the head.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Count width covers occupancies 0..8 (largest legal queue depth).
  localparam int CNT_W = 4;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small circular queue of fetched instructions with flush.
//                Control state is reset; entry storage is not.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count next state; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write; no reset since validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch front end. Issues sequential reads to a
//                one-cycle-latency instruction memory, buffers returns in a
//                small queue and handles decode stalls and execute redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemEn,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  logic [31:0]      pcf_q, pcf_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      infl_pc_q, infl_pc_d;

  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [CNT_W:0]   w_occ;

  assign ValidD = (w_count != '0);
  assign w_pop  = ValidD && !StallD && !PCSrcE;
  assign w_push = inflight_q && !PCSrcE;

  // Occupancy after this cycle's pop, counting the slot reserved by the
  // outstanding request; a new read is only issued if it will have room.
  assign w_occ   = {1'b0, w_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(w_pop);
  assign w_issue = !rst && !PCSrcE && (w_occ < (CNT_W+1)'(DEPTH));

  assign ImemEn   = w_issue;
  assign ImemAddr = pcf_q;

  assign w_push_data.pc    = infl_pc_q;
  assign w_push_data.instr = ImemRdata;

  // Next fetch PC and in-flight tracking; a redirect overrides everything.
  always_comb begin
    pcf_d      = pcf_q;
    infl_pc_d  = infl_pc_q;
    inflight_d = w_issue;
    if (PCSrcE) begin
      pcf_d = PCTargetE & 32'hFFFF_FFFC;
    end else if (w_issue) begin
      pcf_d     = pcf_q + 32'd4;
      infl_pc_d = pcf_q;
    end
  end

  // Fetch PC and in-flight registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q      <= RESET_PC;
      inflight_q <= 1'b0;
      infl_pc_q  <= '0;
    end else begin
      pcf_q      <= pcf_d;
      inflight_q <= inflight_d;
      infl_pc_q  <= infl_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .flush_i     (PCSrcE),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  // Head outputs are gated so nothing undefined leaks out of an empty queue.
  assign InstrD   = ValidD ? w_head.instr : NOP;
  assign PCD      = ValidD ? w_head.pc    : 32'd0;
  assign PCPlus4D = PCD + 32'd4;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a queue-based
//                reference model and an independent head-of-queue monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemEn;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ValidD;
  logic [31:0] InstrD, PCD, PCPlus4D;

  // Second instance exercising address wrap-around.
  logic        w_stall, w_redir;
  logic [31:0] w_tgt;
  logic        w_en;
  logic [31:0] w_addr, w_rdata;
  logic        w_valid;
  logic [31:0] w_instr, w_pcd, w_pcp4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ImemEn(ImemEn), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata),
    .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst), .StallD(w_stall), .PCSrcE(w_redir), .PCTargetE(w_tgt),
    .ImemEn(w_en), .ImemAddr(w_addr), .ImemRdata(w_rdata),
    .ValidD(w_valid), .InstrD(w_instr), .PCD(w_pcd), .PCPlus4D(w_pcp4)
  );

  // Memory contents: a fixed scramble of the address, so each word is tagged.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5677;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  fetch_entry_t exp_q[$];     // instructions expected to reach decode, in order
  int           mcount;       // entries the model holds in its queue
  bit           minf;         // model has a read outstanding
  logic [31:0]  minf_pc;
  logic [31:0]  mpc;          // model's next fetch address
  logic         prev_en;
  logic [31:0]  prev_addr;

  task automatic model_reset();
    exp_q.delete();
    mcount  = 0;
    minf    = 0;
    minf_pc = '0;
    mpc     = RESET_PC;
    prev_en = 1'b0;
    prev_addr = '0;
  endtask

  // One clock cycle. Entered and left at posedge+1.
  task automatic one_cycle(input logic stall, input logic redir, input logic [31:0] tgt);
    bit mpop, exp_en;
    fetch_entry_t e;
    StallD = stall; PCSrcE = redir; PCTargetE = tgt;
    @(negedge clk); #1;
    mpop   = (mcount > 0) && !stall && !redir;
    exp_en = !redir && ((mcount + int'(minf) - int'(mpop)) < DEPTH);
    chk("ImemEn", 32'(ImemEn), 32'(exp_en));
    chk("ValidD", 32'(ValidD), 32'(mcount != 0));
    if (exp_en && ImemEn) chk("ImemAddr", ImemAddr, mpc);
    prev_en   = ImemEn;
    prev_addr = ImemAddr;
    if (redir) begin
      exp_q.delete();
      mcount = 0;
      minf   = 0;
      mpc    = tgt & 32'hFFFF_FFFC;
    end else begin
      mcount = mcount - int'(mpop) + int'(minf);
      if (minf) begin
        e.pc = minf_pc; e.instr = mem_word(minf_pc);
        exp_q.push_back(e);
      end
      minf = exp_en;
      if (exp_en) begin
        minf_pc = mpc;
        mpc     = mpc + 32'd4;
      end
    end
    @(posedge clk); #1;
    ImemRdata = prev_en ? mem_word(prev_addr) : $urandom;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    fetch_entry_t h;
    if (!rst) begin
      if (!ValidD) begin
        chk("InstrD_nop", InstrD, NOP);
      end else if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL head: got pc %h with no expected entry at %0t", PCD, $time);
      end else begin
        h = exp_q[0];
        chk("PCD", PCD, h.pc);
        chk("InstrD", InstrD, h.instr);
        chk("PCPlus4D", PCPlus4D, h.pc + 32'd4);
        if (!StallD && !PCSrcE) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- wrap-around instance ----------------
  initial begin
    logic        en_s;
    logic [31:0] addr_s;
    int          k;
    logic [31:0] pe;
    w_stall = 1'b0; w_redir = 1'b0; w_tgt = '0; w_rdata = '0;
    k = 0;
    @(negedge rst);
    repeat (8) begin
      @(negedge clk);
      if (w_valid) begin
        pe = WRAP_PC + 32'(4 * k);
        chk("wrap_PCD", w_pcd, pe);
        chk("wrap_PCPlus4D", w_pcp4, pe + 32'd4);
        chk("wrap_InstrD", w_instr, mem_word(pe));
        k++;
      end
      en_s = w_en; addr_s = w_addr;
      @(posedge clk); #1;
      w_rdata = en_s ? mem_word(addr_s) : 32'd0;
    end
    chk("wrap_pops", 32'(k >= 3), 32'd1);
  end

  // ---------------- main stimulus ----------------
  initial begin
    rst = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; ImemRdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ValidD", 32'(ValidD), 32'd0);
    chk("rst_ImemEn", 32'(ImemEn), 32'd0);
    chk("rst_InstrD", InstrD, NOP);
    rst = 1'b0;

    // Free run: head reaches PC 8 after four cycles, then stall on it.
    repeat (4) one_cycle(1'b0, 1'b0, '0);
    chk("head_before_stall", PCD, 32'h8);
    repeat (5) one_cycle(1'b1, 1'b0, '0);
    // Redirect while full (stall keeps it full); target fetch comes next.
    one_cycle(1'b1, 1'b1, 32'h0000_0100);
    repeat (4) one_cycle(1'b0, 1'b0, '0);
    // Misaligned target is word-aligned.
    one_cycle(1'b0, 1'b1, 32'h0000_0103);
    repeat (6) one_cycle(1'b0, 1'b0, '0);
    // Back-to-back redirects: last wins.
    one_cycle(1'b0, 1'b1, 32'h0000_2000);
    one_cycle(1'b1, 1'b1, 32'h0000_3000);
    repeat (3) one_cycle(1'b1, 1'b0, '0);

    // Asynchronous reset with a full queue: outputs drop before the next edge.
    #2 rst = 1'b1;
    #1;
    chk("async_ValidD", 32'(ValidD), 32'd0);
    chk("async_ImemEn", 32'(ImemEn), 32'd0);
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    repeat (6) one_cycle(1'b0, 1'b0, '0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      one_cycle(1'($urandom_range(0, 99) < 30),
                1'($urandom_range(0, 99) < 6),
                $urandom);
    end
    repeat (4) one_cycle(1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
